ds_operand_stage: RTL
=====================

DS_OPERAND_STAGE -- requirements
Module: ds_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the register data width.
REQ-002 SHALL have parameter N_FWD, default 3, the number of bypass sources; index 0 is the youngest (es), then ms, then ws.
REQ-003 SHALL have parameter PAYLOAD_W, default 64, the fetch payload width ({pc, inst}).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port fs_to_ds_valid  in  1  fetch slot valid.
REQ-007 SHALL have port fs_to_ds_bus  in  PAYLOAD_W  fetch payload.
REQ-008 SHALL have port ds_allowin  out  1  decode slot can accept.
REQ-009 SHALL have port es_allowin  in  1  execute stage can accept.
REQ-010 SHALL have port ds_to_es_valid  out  1  slot valid and ready to advance.
REQ-011 SHALL have port ds_payload  out  PAYLOAD_W  registered payload, for the external decoder.
REQ-012 SHALL have port flush  in  1  kill the slot (branch taken or exception).
REQ-013 SHALL have ports raddr1, raddr2  in  5 each  source register numbers from the decoder.
REQ-014 SHALL have ports use1, use2  in  1 each  source operand is actually consumed.
REQ-015 SHALL have ports rf_raddr1, rf_raddr2  out  5 each  regfile read addresses.
REQ-016 SHALL have ports rf_rdata1, rf_rdata2  in  XLEN each  regfile read data.
REQ-017 SHALL have ports fwd_valid, fwd_we, fwd_ready  in  N_FWD each  per source: stage valid, writes a register, result available.
REQ-018 SHALL have port fwd_waddr  in  5*N_FWD  packed destination registers.
REQ-019 SHALL have port fwd_wdata  in  XLEN*N_FWD  packed results.
REQ-020 SHALL have ports src1_value, src2_value  out  XLEN each  resolved operands.
REQ-021 SHALL have port stall_cnt  out  16  count of interlock cycles.

Function
REQ-022 SHALL register the payload when fs_to_ds_valid && ds_allowin; otherwise the payload holds.
REQ-023 SHALL assert ds_allowin = !ds_valid || (ready_go && es_allowin).
REQ-024 SHALL load ds_valid with fs_to_ds_valid at a clock edge where ds_allowin is high.
REQ-025 SHALL give flush priority over load: a flush clears ds_valid at the next edge, even if a new fetch is offered in the same cycle.
REQ-026 SHALL drive rf_raddrN = raddrN combinationally.
REQ-027 SHALL define hit_i(N) = fwd_valid[i] && fwd_we[i] && fwd_waddr[i] == raddrN && raddrN != 0.
REQ-028 SHALL select the lowest-index hit as the bypass source; with no hit, srcN_value = rf_rdataN.
REQ-029 SHALL block operand N when the selected source has fwd_ready == 0; older sources SHALL NOT be used in that case.
REQ-030 SHALL never bypass register 0; a read of register 0 returns rf_rdataN.
REQ-031 SHALL compute ready_go = !(use1 && blocked1) && !(use2 && blocked2); a blocked operand with useN = 0 does not stall.
REQ-032 SHALL drive ds_to_es_valid = ds_valid && ready_go && !flush.
REQ-033 SHALL make bypass fully combinational, with zero-cycle latency from fwd_* to srcN_value.
REQ-034 SHALL increment stall_cnt on each cycle where ds_valid && !ready_go, saturating at 16'hFFFF.
REQ-035 SHALL hold the payload and operands stable while ds_valid && !ds_allowin.

Reset
REQ-036 SHALL, while reset is high, force ds_valid = 0, payload = 0 and stall_cnt = 0 immediately, independent of clk.
REQ-037 SHALL hold ds_allowin = 1 and ds_to_es_valid = 0 during reset.
REQ-038 SHALL discard an in-flight stalled instruction if reset asserts mid-stall; no partial state survives.

Structure
REQ-039 SHALL place the bus widths (FS_TO_DS_BUS_WD) and the bypass-source index names in the shared mycpu.vh header.
REQ-040 SHALL implement per-operand source selection as one sub-module, ds_bypass_sel, instantiated twice.
REQ-041 SHALL contain no regfile; the regfile stays outside this block.

Verification
REQ-042 SHALL cover this directed scenario: raddr1=5, fwd0 {valid, we, ready}=1, waddr=5, wdata=0x11; fwd2 also hits with 0x33 -> src1_value=0x11, ready_go=1.
REQ-043 SHALL cover this directed scenario: raddr2=7, use2=1, fwd0 hits with ready=0 for 3 cycles -> ds_to_es_valid=0 and ds_allowin=0 for 3 cycles, stall_cnt=3, then a single advance.
REQ-044 SHALL cover this directed scenario: same hit as REQ-043 but use2=0 -> no stall, and stall_cnt stays 0.
REQ-045 SHALL cover this directed scenario: raddr1=0, fwd0 writes register 0 with 0xDEAD -> src1_value=rf_rdata1=0.
REQ-046 SHALL cover this directed scenario: flush together with fs_to_ds_valid=1 while ds_valid=1 -> ds_valid=0 next cycle, and ds_to_es_valid=0 in the flush cycle.
REQ-047 SHALL cover this directed scenario: reset pulse mid-stall between clock edges -> ds_valid and stall_cnt go to 0 immediately; stall_cnt forced to 0xFFFF still saturates there after a further stall cycle.

Source files
------------

// File: rtl/ds_operand_stage_pkg.sv
// Shared bus widths, bypass-source index names and limits for the decode stage.
package ds_operand_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam int unsigned REG_ADDR_W      = 5;

  // Bypass sources, youngest first.
  localparam int unsigned FWD_ES = 0;
  localparam int unsigned FWD_MS = 1;
  localparam int unsigned FWD_WS = 2;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ds_bypass_sel.sv
// Per-operand bypass selection: youngest matching producer wins, r0 never bypassed.
module ds_bypass_sel
  import ds_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N_FWD = 3
) (
  input  logic [REG_ADDR_W-1:0]       raddr,
  input  logic [XLEN-1:0]             rf_rdata,
  input  logic [N_FWD-1:0]            fwd_valid,
  input  logic [N_FWD-1:0]            fwd_we,
  input  logic [N_FWD-1:0]            fwd_ready,
  input  logic [REG_ADDR_W*N_FWD-1:0] fwd_waddr,
  input  logic [XLEN*N_FWD-1:0]       fwd_wdata,
  output logic [XLEN-1:0]             value,
  output logic                        blocked
);

  logic found;

  // Once the youngest hit is taken, older sources are ignored even if it is not ready.
  always_comb begin
    value   = rf_rdata;
    blocked = 1'b0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_FWD; i++) begin
      if (!found && fwd_valid[i] && fwd_we[i] && (raddr != '0) &&
          (fwd_waddr[i*REG_ADDR_W +: REG_ADDR_W] == raddr)) begin
        found   = 1'b1;
        value   = fwd_wdata[i*XLEN +: XLEN];
        blocked = !fwd_ready[i];
      end
    end
  end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage slot: payload register, operand bypass/interlock and stall counter.
module ds_operand_stage
  import ds_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned N_FWD     = 3,
  parameter int unsigned PAYLOAD_W = FS_TO_DS_BUS_WD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fs_to_ds_valid,
  input  logic [PAYLOAD_W-1:0]        fs_to_ds_bus,
  output logic                        ds_allowin,
  input  logic                        es_allowin,
  output logic                        ds_to_es_valid,
  output logic [PAYLOAD_W-1:0]        ds_payload,
  input  logic                        flush,
  input  logic [REG_ADDR_W-1:0]       raddr1,
  input  logic [REG_ADDR_W-1:0]       raddr2,
  input  logic                        use1,
  input  logic                        use2,
  output logic [REG_ADDR_W-1:0]       rf_raddr1,
  output logic [REG_ADDR_W-1:0]       rf_raddr2,
  input  logic [XLEN-1:0]             rf_rdata1,
  input  logic [XLEN-1:0]             rf_rdata2,
  input  logic [N_FWD-1:0]            fwd_valid,
  input  logic [N_FWD-1:0]            fwd_we,
  input  logic [N_FWD-1:0]            fwd_ready,
  input  logic [REG_ADDR_W*N_FWD-1:0] fwd_waddr,
  input  logic [XLEN*N_FWD-1:0]       fwd_wdata,
  output logic [XLEN-1:0]             src1_value,
  output logic [XLEN-1:0]             src2_value,
  output logic [15:0]                 stall_cnt
);

  logic                 ds_valid;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [15:0]          stall_cnt_q;
  logic                 blocked1;
  logic                 blocked2;
  logic                 ready_go;

  assign rf_raddr1 = raddr1;
  assign rf_raddr2 = raddr2;

  ds_bypass_sel #(
    .XLEN  (XLEN),
    .N_FWD (N_FWD)
  ) u_sel1 (
    .raddr     (raddr1),
    .rf_rdata  (rf_rdata1),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_ready (fwd_ready),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .value     (src1_value),
    .blocked   (blocked1)
  );

  ds_bypass_sel #(
    .XLEN  (XLEN),
    .N_FWD (N_FWD)
  ) u_sel2 (
    .raddr     (raddr2),
    .rf_rdata  (rf_rdata2),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_ready (fwd_ready),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .value     (src2_value),
    .blocked   (blocked2)
  );

  assign ready_go       = !(use1 && blocked1) && !(use2 && blocked2);
  assign ds_allowin     = !ds_valid || (ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ready_go && !flush;
  assign ds_payload     = payload_q;
  assign stall_cnt      = stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid <= 1'b0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload_q <= '0;
    end else if (fs_to_ds_valid && ds_allowin) begin
      payload_q <= fs_to_ds_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (ds_valid && !ready_go && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
